// File: rtl/merge_sort_pkg.sv
// Shared types and constants for the merge-sort lower layer.
// Holds the sequencer state encoding, the default element width and the
// merged-length helper used to size collector and output vectors.
package merge_sort_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  typedef logic [DATA_W_DEF-1:0] elem_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    RUN,
    HOLD
  } seq_state_e;

  // Number of words produced by merging two runs of run_len elements.
  function automatic int unsigned mrg_len(input int unsigned run_len);
    return 2 * run_len;
  endfunction

endpackage

// File: rtl/lower_layer_2_1_collector.sv
// Merged-word collector for the 2:1 lower-layer sequencer.
// Stores strobed words at the running index and keeps a saturating word
// count; a write at full count is dropped and flagged on ovf.
module lower_layer_2_1_collector #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MRG_LEN = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        wr,
  input  logic [DATA_W-1:0]           wdata,
  output logic [MRG_LEN*DATA_W-1:0]   vec,
  output logic [CNT_W-1:0]            cnt,
  output logic                        ovf
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(MRG_LEN);

  logic [MRG_LEN*DATA_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  // Clear wipes every word so unfilled slots read back as zero.
  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    if (clr) begin
      vec_d = '0;
      cnt_d = '0;
    end else if (wr && (cnt_q != FULL)) begin
      for (int unsigned i = 0; i < MRG_LEN; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          vec_d[i*DATA_W +: DATA_W] = wdata;
        end
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Word buffer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

  assign vec = vec_q;
  assign cnt = cnt_q;
  assign ovf = wr && !clr && (cnt_q == FULL);

endmodule

// File: rtl/lower_layer_2_1_sequencer.sv
// Initiator side of the 2:1 lower-layer merge interface.
// Buffers one pending (A, B) run pair, launches the merge layer with a
// one-cycle load pulse, collects the strobed merged words and presents the
// merged vector downstream on valid/ready.
// Optional watchdog: define LL_SEQ_TIMEOUT_EN to abort a merge whose done
// never arrives after TIMEOUT_CYC cycles (sets err_tmo, emits partial vector).
module lower_layer_2_1_sequencer
  import merge_sort_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned RUN_LEN     = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [RUN_LEN*DATA_W-1:0]              in_run_a,
  input  logic [RUN_LEN*DATA_W-1:0]              in_run_b,
  output logic                                   ml_load,
  output logic [RUN_LEN*DATA_W-1:0]              ml_run_a,
  output logic [RUN_LEN*DATA_W-1:0]              ml_run_b,
  input  logic                                   ml_done,
  input  logic                                   ml_word_vld,
  input  logic [DATA_W-1:0]                      ml_word,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [mrg_len(RUN_LEN)*DATA_W-1:0]     out_data,
  output logic                                   busy,
  output logic                                   err_len,
  output logic                                   err_tmo
);

  localparam int unsigned MRG_LEN = mrg_len(RUN_LEN);
  localparam int unsigned RUN_W   = RUN_LEN * DATA_W;
  localparam int unsigned VEC_W   = MRG_LEN * DATA_W;
  localparam int unsigned CNT_W   = $clog2(MRG_LEN + 1);
  localparam logic [CNT_W-1:0] MRG_CNT = CNT_W'(MRG_LEN);

  seq_state_e       state_q, state_d;
  logic             pend_full_q, pend_full_d;
  logic [RUN_W-1:0] pend_a_q, pend_a_d;
  logic [RUN_W-1:0] pend_b_q, pend_b_d;
  logic [RUN_W-1:0] ml_run_a_q, ml_run_a_d;
  logic [RUN_W-1:0] ml_run_b_q, ml_run_b_d;
  logic             out_valid_q, out_valid_d;
  logic [VEC_W-1:0] out_data_q, out_data_d;
  logic             err_len_q, err_len_d;

  logic             out_free;
  logic             coll_clr;
  logic             coll_wr;
  logic [VEC_W-1:0] coll_vec;
  logic [CNT_W-1:0] coll_cnt;
  logic             coll_ovf;

`ifdef LL_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_tmo_q, err_tmo_d;
`endif

  // Collector is cleared on launch and only listens while in RUN.
  assign coll_clr = (state_q == LOAD);
  assign coll_wr  = (state_q == RUN) && ml_word_vld;

  lower_layer_2_1_collector #(
    .DATA_W  (DATA_W),
    .MRG_LEN (MRG_LEN),
    .CNT_W   (CNT_W)
  ) u_collector (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (coll_clr),
    .wr    (coll_wr),
    .wdata (ml_word),
    .vec   (coll_vec),
    .cnt   (coll_cnt),
    .ovf   (coll_ovf)
  );

  assign out_free = !out_valid_q || out_ready;

  // Next-state, pending slot, output register and sticky error logic.
  // The run pair is copied to ml_run_a/b on the edge into LOAD so the
  // merge layer sees stable runs together with the load pulse.
  always_comb begin
    state_d     = state_q;
    pend_full_d = pend_full_q;
    pend_a_d    = pend_a_q;
    pend_b_d    = pend_b_q;
    ml_run_a_d  = ml_run_a_q;
    ml_run_b_d  = ml_run_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_len_d   = err_len_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pend_full_q && out_free) begin
          ml_run_a_d  = pend_a_q;
          ml_run_b_d  = pend_b_q;
          pend_full_d = 1'b0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        state_d = CLR;
      end
      CLR: begin
        if (!ml_done) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (coll_ovf) begin
          err_len_d = 1'b1;
        end
        if (ml_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = coll_vec;
          if (coll_cnt != MRG_CNT) begin
            err_len_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_valid && !pend_full_q) begin
      pend_full_d = 1'b1;
      pend_a_d    = in_run_a;
      pend_b_d    = in_run_b;
    end

`ifdef LL_SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_tmo_d = err_tmo_q;
    if (state_q == LOAD) begin
      tmo_cnt_d = '0;
    end else if ((state_q == CLR) || (state_q == RUN)) begin
      // Watchdog overrides the normal transition; the cleared collector
      // supplies zeros for any words that never arrived.
      if (tmo_cnt_q == TMO_LAST) begin
        err_tmo_d = 1'b1;
        state_d   = HOLD;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
`endif
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_full_q <= 1'b0;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
      ml_run_a_q  <= '0;
      ml_run_b_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_full_q <= pend_full_d;
      pend_a_q    <= pend_a_d;
      pend_b_q    <= pend_b_d;
      ml_run_a_q  <= ml_run_a_d;
      ml_run_b_q  <= ml_run_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_len_q   <= err_len_d;
    end
  end

`ifdef LL_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign err_tmo = err_tmo_q;
`else
  assign err_tmo = 1'b0;
`endif

  assign in_ready  = !pend_full_q;
  assign ml_load   = (state_q == LOAD);
  assign ml_run_a  = ml_run_a_q;
  assign ml_run_b  = ml_run_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_lower_layer_2_1_sequencer.sv
// Self-checking bench for lower_layer_2_1_sequencer (default build).
// A behavioural merge layer answers each load; expected merged vectors are
// queued when a pair is offered and compared when the output handshakes.
module tb_lower_layer_2_1_sequencer;
  import merge_sort_pkg::*;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned RUN_LEN = 2;
  localparam int unsigned MRG_LEN = 4;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [RUN_LEN*DATA_W-1:0]   in_run_a;
  logic [RUN_LEN*DATA_W-1:0]   in_run_b;
  logic                        ml_load;
  logic [RUN_LEN*DATA_W-1:0]   ml_run_a;
  logic [RUN_LEN*DATA_W-1:0]   ml_run_b;
  logic                        ml_done;
  logic                        ml_word_vld;
  logic [DATA_W-1:0]           ml_word;
  logic                        out_valid;
  logic                        out_ready;
  logic [MRG_LEN*DATA_W-1:0]   out_data;
  logic                        busy;
  logic                        err_len;
  logic                        err_tmo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int load_cnt = 0;
  int strobes_done = 0;
  int mdl_nwords = 4;
  int mdl_stale = 0;
  int load_cyc_q[$];
  int ov_cyc_q[$];
  logic [MRG_LEN*DATA_W-1:0] exp_q[$];

  lower_layer_2_1_sequencer #(
    .DATA_W      (DATA_W),
    .RUN_LEN     (RUN_LEN),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_run_a    (in_run_a),
    .in_run_b    (in_run_b),
    .ml_load     (ml_load),
    .ml_run_a    (ml_run_a),
    .ml_run_b    (ml_run_b),
    .ml_done     (ml_done),
    .ml_word_vld (ml_word_vld),
    .ml_word     (ml_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .err_len     (err_len),
    .err_tmo     (err_tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack2(input elem_t e0, input elem_t e1);
    return {e1, e0};
  endfunction

  function automatic logic [63:0] merge_runs(input logic [31:0] a, input logic [31:0] b);
    elem_t ea [2];
    elem_t eb [2];
    int ia, ib;
    logic [63:0] r;
    ea[0] = a[15:0]; ea[1] = a[31:16];
    eb[0] = b[15:0]; eb[1] = b[31:16];
    ia = 0; ib = 0; r = '0;
    for (int k = 0; k < 4; k++) begin
      if (ib >= 2 || (ia < 2 && ea[ia] <= eb[ib])) begin
        r[k*16 +: 16] = ea[ia]; ia++;
      end else begin
        r[k*16 +: 16] = eb[ib]; ib++;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] expect_vec(input logic [31:0] a, input logic [31:0] b, input int n);
    logic [63:0] m;
    m = merge_runs(a, b);
    for (int k = 0; k < 4; k++) begin
      if (k >= n) m[k*16 +: 16] = '0;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Behavioural merge layer: keeps the previous done level for a while,
  // drops it, strobes the merged words, raising done with the last strobe.
  initial begin : merge_model
    logic [63:0] m;
    ml_done = 1'b0; ml_word_vld = 1'b0; ml_word = '0;
    forever begin
      tick();
      if (ml_load === 1'b1) begin
        m = merge_runs(ml_run_a, ml_run_b);
        repeat (1 + mdl_stale) tick();
        ml_done = 1'b0;
        tick();
        for (int k = 0; k < mdl_nwords; k++) begin
          ml_word_vld = 1'b1;
          ml_word = (k < 4) ? m[k*16 +: 16] : 16'hBEEF;
          if (k == mdl_nwords - 1) ml_done = 1'b1;
          tick();
          strobes_done++;
        end
        ml_word_vld = 1'b0;
        ml_word = '0;
        ml_done = 1'b1;
      end
    end
  end

  // Output monitor: scoreboard pop on handshake, hold-stability, load pulse width.
  initial begin : monitor
    logic ov_prev, ld_prev, held_vld;
    logic [63:0] held, e;
    ov_prev = 1'b0; ld_prev = 1'b0; held_vld = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (ml_load === 1'b1) begin
          checks++;
          if (ld_prev) begin
            failures++;
            $display("FAIL load_pulse_width: ml_load high %0d cycles in a row, required 1", 2);
          end
          load_cnt++;
          load_cyc_q.push_back(cyc);
        end
        if (out_valid === 1'b1 && !ov_prev) ov_cyc_q.push_back(cyc);
        if (held_vld && out_valid === 1'b1) begin
          checks++;
          if (out_data !== held) begin
            failures++;
            $display("FAIL out_hold_stable: out_data=%h required %h", out_data, held);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: out_data=%h required no output", out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
              failures++;
              $display("FAIL out_data: got %h required %h", out_data, e);
            end
          end
          held_vld = 1'b0;
        end else if (out_valid === 1'b1) begin
          held = out_data;
          held_vld = 1'b1;
        end else begin
          held_vld = 1'b0;
        end
      end else begin
        held_vld = 1'b0;
      end
      ov_prev = (out_valid === 1'b1);
      ld_prev = (ml_load === 1'b1);
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input int n);
    int w;
    exp_q.push_back(expect_vec(a, b, n));
    in_run_a = a; in_run_b = b; in_valid = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 300) begin tick(); w++; end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL offer_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_load(output bit ok);
    int w;
    w = 0;
    while (ml_load !== 1'b1 && w < 300) begin tick(); w++; end
    ok = (ml_load === 1'b1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL load_timeout: ml_load=%b required 1", ml_load);
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin tick(); w++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_run_a = '0; in_run_b = '0; out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ml_load, busy, out_valid, err_len, err_tmo} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: load,busy,ovld,elen,etmo=%b required 00000",
               {ml_load, busy, out_valid, err_len, err_tmo});
    end
    checks++;
    if ({out_data, ml_run_a, ml_run_b} !== '0) begin
      failures++;
      $display("FAIL reset_data: out=%h a=%h b=%h required 0", out_data, ml_run_a, ml_run_b);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int base;
    base = load_cnt;
    offer(pack2(3, 9), pack2(5, 7), 4);
    wait_drain();
    checks++;
    if (load_cnt - base != 1) begin
      failures++;
      $display("FAIL single_load_count: got %0d required 1", load_cnt - base);
    end
    checks++;
    if (err_len !== 1'b0) begin
      failures++;
      $display("FAIL single_err_len: got %b required 0", err_len);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    load_cyc_q.delete(); ov_cyc_q.delete();
    offer(pack2(1, 2), pack2(3, 4), 4);
    offer(pack2(10, 40), pack2(20, 30), 4);
    checks++;
    if ({in_ready, busy} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_slot_full: in_ready,busy=%b required 01", {in_ready, busy});
    end
    tick();
    wait_load(ok);
    if (ok) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_slot_freed: in_ready=%b required 1", in_ready);
      end
    end
    wait_drain();
    checks++;
    if (load_cyc_q.size() != 2 || ov_cyc_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_events: loads=%0d outs=%0d required 2 2", load_cyc_q.size(), ov_cyc_q.size());
    end else begin
      checks++;
      if (load_cyc_q[1] - ov_cyc_q[0] != 1) begin
        failures++;
        $display("FAIL b2b_relaunch_gap: got %0d cycles required 1", load_cyc_q[1] - ov_cyc_q[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base, w;
    logic [63:0] e2;
    base = load_cnt;
    out_ready = 1'b1;
    e2 = expect_vec(pack2(50, 300), pack2(100, 200), 4);
    offer(pack2(7, 7), pack2(7, 8), 4);
    offer(pack2(50, 300), pack2(100, 200), 4);
    w = 0;
    while (load_cnt < base + 2 && w < 300) begin tick(); w++; end
    out_ready = 1'b0;
    offer(pack2(0, 16'hFFFF), pack2(1, 2), 4);
    w = 0;
    while (out_valid !== 1'b1 && w < 300) begin tick(); w++; end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_out_valid: out_valid=%b required 1", out_valid);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || load_cnt != base + 2) begin
        failures++;
        $display("FAIL bp_stall: in_ready=%b loads=%0d required 0 %0d", in_ready, load_cnt - base, 2);
      end
    end
    checks++;
    if (out_data !== e2 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_held_data: out=%h vld=%b required %h 1", out_data, out_valid, e2);
    end
    out_ready = 1'b1;
    wait_drain();
    checks++;
    if (load_cnt - base != 3) begin
      failures++;
      $display("FAIL bp_final_loads: got %0d required 3", load_cnt - base);
    end
  endtask

  task automatic test_stale_done();
    bit ok;
    mdl_stale = 3;
    offer(pack2(4, 6), pack2(1, 9), 4);
    wait_load(ok);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({out_valid, busy} !== 2'b01) begin
        failures++;
        $display("FAIL stale_done_wait: out_valid,busy=%b required 01", {out_valid, busy});
      end
    end
    wait_drain();
    mdl_stale = 0;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int base, w;
    offer(pack2(2, 3), pack2(1, 4), 4);
    wait_load(ok);
    base = strobes_done;
    w = 0;
    while (strobes_done < base + 2 && w < 100) begin tick(); w++; end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({ml_load, busy, out_valid, err_len} !== 4'b0 || {out_data, ml_run_a, ml_run_b} !== '0) begin
      failures++;
      $display("FAIL midrun_reset: flags=%b out=%h a=%h required 0",
               {ml_load, busy, out_valid, err_len}, out_data, ml_run_a);
    end
    exp_q.delete();
    rst_n = 1'b1;
    repeat (15) tick();
    offer(pack2(11, 13), pack2(12, 14), 4);
    wait_drain();
    checks++;
    if (err_len !== 1'b0) begin
      failures++;
      $display("FAIL midrun_err_len: got %b required 0", err_len);
    end
  endtask

  task automatic test_len_short();
    mdl_nwords = 3;
    offer(pack2(3, 9), pack2(5, 7), 3);
    wait_drain();
    checks++;
    if (err_len !== 1'b1) begin
      failures++;
      $display("FAIL len_short_err: err_len=%b required 1", err_len);
    end
    mdl_nwords = 4;
  endtask

  task automatic test_len_long();
    mdl_nwords = 5;
    offer(pack2(20, 21), pack2(5, 30), 4);
    wait_drain();
    checks++;
    if (err_len !== 1'b1) begin
      failures++;
      $display("FAIL len_long_err: err_len=%b required 1", err_len);
    end
    mdl_nwords = 4;
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_stale_done();
    test_reset_mid_run();
    test_len_short();
    apply_reset();
    checks++;
    if (err_len !== 1'b0) begin
      failures++;
      $display("FAIL err_len_cleared: got %b required 0", err_len);
    end
    test_len_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

endmodule
